// File: rtl/conv_feed_pkg.sv
// Shared definitions for the conv unit input feed path: sequencer state
// encoding and the drain length helper.
package conv_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

  // Cycles needed after the last read until the final lane has seen it:
  // buffer read latency plus the skew depth (lanes - 1).
  function automatic int drain_cycles(input int rd_latency, input int lane_num);
    return rd_latency + lane_num - 1;
  endfunction

endpackage

// File: rtl/lane_valid_skew.sv
// Per-lane valid tracker that mirrors the skew register array: a 1-bit
// shift chain, one stage per byte lane, with synchronous active-low clear.
module lane_valid_skew #(
  parameter int LANES = 9
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic [LANES-1:0] lane_valid
);

  logic [LANES-1:0] lane_q;
  logic [LANES-1:0] lane_d;

  // Shift the incoming valid bit one lane further each cycle.
  always_comb begin
    lane_d    = lane_q << 1;
    lane_d[0] = in_valid;
    if (!clr_n) begin
      lane_d = '0;
    end
  end

  // Register the chain.
  always_ff @(posedge clk) begin
    lane_q <= lane_d;
  end

  assign lane_valid = lane_q;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Input skew path sequencer: reads vectors from the input feature buffer,
// marks real data vs. zero bubbles per lane, drains the skew array after
// each pass and repeats the stream for the configured number of passes.
// The skew array has no enable, so this block never stalls it.
module systolic_feed_ctrl
  import conv_feed_pkg::*;
#(
  parameter int REG_IN_CHANNEL_NUM = 9,
  parameter int ADDR_WIDTH         = 10,
  parameter int LEN_WIDTH          = 10,
  parameter int PASS_WIDTH         = 8,
  parameter int BUF_RD_LATENCY     = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]          cfg_vec_num,
  input  logic [PASS_WIDTH-1:0]         cfg_pass_num,
  input  logic                          buf_avail,
  output logic                          buf_rd_en,
  output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
  output logic                          feed_valid,
  output logic                          feed_zero,
  output logic [REG_IN_CHANNEL_NUM-1:0] lane_valid,
  output logic [PASS_WIDTH-1:0]         pass_idx,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    dbg_state
);

  localparam int DRAIN_LEN = drain_cycles(BUF_RD_LATENCY, REG_IN_CHANNEL_NUM);
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  // Handshake: buf_rd_en is a one-way strobe qualified by buf_avail in the
  // same cycle; a cycle in FEED with buf_avail=0 issues no read and becomes
  // a zero bubble BUF_RD_LATENCY cycles later. There is no backpressure
  // toward the skew array.

  feed_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [LEN_WIDTH-1:0]      vec_num_q, vec_num_d;
  logic [PASS_WIDTH-1:0]     pass_last_q, pass_last_d;
  logic [LEN_WIDTH-1:0]      vec_idx_q, vec_idx_d;
  logic [PASS_WIDTH-1:0]     pass_q, pass_d;
  logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic [DCW-1:0]            drain_q, drain_d;
  logic [BUF_RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      feed_zero_q, feed_zero_d;

  // Next-state, counter and address logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    vec_num_d   = vec_num_q;
    pass_last_d = pass_last_q;
    vec_idx_d   = vec_idx_q;
    pass_d      = pass_q;
    rd_addr_d   = rd_addr_q;
    drain_d     = drain_q;
    buf_rd_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = cfg_base_addr;
          vec_num_d   = cfg_vec_num;
          pass_last_d = (cfg_pass_num == '0) ? '0 : cfg_pass_num - 1'b1;
          vec_idx_d   = '0;
          pass_d      = '0;
          rd_addr_d   = cfg_base_addr;
          state_d     = (cfg_vec_num == '0) ? ST_DONE : ST_FEED;
        end
      end
      ST_FEED: begin
        buf_rd_en = buf_avail;
        if (buf_avail) begin
          vec_idx_d = vec_idx_q + 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          if (vec_idx_q == vec_num_q - 1'b1) begin
            state_d = ST_DRAIN;
            drain_d = DCW'(DRAIN_LEN);
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == DCW'(1)) begin
          if (pass_q == pass_last_q) begin
            state_d = ST_DONE;
          end else begin
            // Next pass re-reads the same address range.
            pass_d    = pass_q + 1'b1;
            vec_idx_d = '0;
            rd_addr_d = base_q;
            state_d   = ST_FEED;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!rstn) begin
      state_d     = ST_IDLE;
      base_d      = '0;
      vec_num_d   = '0;
      pass_last_d = '0;
      vec_idx_d   = '0;
      pass_d      = '0;
      rd_addr_d   = '0;
      drain_d     = '0;
    end
  end

  // Read-strobe delay line modelling the buffer latency, and the status
  // outputs derived from the next state.
  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = buf_rd_en;
    if (!rstn) begin
      rd_pipe_d = '0;
    end
    busy_d      = (state_d == ST_FEED) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    feed_zero_d = busy_d & ~rd_pipe_d[BUF_RD_LATENCY-1];
  end

  // Register the FSM, counters and outputs.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    base_q      <= base_d;
    vec_num_q   <= vec_num_d;
    pass_last_q <= pass_last_d;
    vec_idx_q   <= vec_idx_d;
    pass_q      <= pass_d;
    rd_addr_q   <= rd_addr_d;
    drain_q     <= drain_d;
    rd_pipe_q   <= rd_pipe_d;
    busy_q      <= busy_d;
    done_q      <= done_d;
    feed_zero_q <= feed_zero_d;
  end

  // Lane 0 tracks feed_valid itself, so the chain is fed with the
  // next-cycle value of the last latency stage.
  lane_valid_skew #(
    .LANES(REG_IN_CHANNEL_NUM)
  ) u_lane_valid_skew (
    .clk       (clk),
    .clr_n     (rstn),
    .in_valid  (rd_pipe_d[BUF_RD_LATENCY-1]),
    .lane_valid(lane_valid)
  );

  assign buf_rd_addr = rd_addr_q;
  assign feed_valid  = rd_pipe_q[BUF_RD_LATENCY-1];
  assign feed_zero   = feed_zero_q;
  assign pass_idx    = pass_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: per-cycle vector tables for the
// single-pass cases plus hand-written multi-pass, zero-length and reset runs.
module tb_systolic_feed_ctrl;

  localparam int CH  = 9;
  localparam int AW  = 10;
  localparam int LW  = 10;
  localparam int PW  = 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] cfg_base_addr;
  logic [LW-1:0] cfg_vec_num;
  logic [PW-1:0] cfg_pass_num;
  logic          buf_avail;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic          feed_valid;
  logic          feed_zero;
  logic [CH-1:0] lane_valid;
  logic [PW-1:0] pass_idx;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  systolic_feed_ctrl #(
    .REG_IN_CHANNEL_NUM(CH),
    .ADDR_WIDTH        (AW),
    .LEN_WIDTH         (LW),
    .PASS_WIDTH        (PW),
    .BUF_RD_LATENCY    (LAT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .cfg_base_addr(cfg_base_addr),
    .cfg_vec_num  (cfg_vec_num),
    .cfg_pass_num (cfg_pass_num),
    .buf_avail    (buf_avail),
    .buf_rd_en    (buf_rd_en),
    .buf_rd_addr  (buf_rd_addr),
    .feed_valid   (feed_valid),
    .feed_zero    (feed_zero),
    .lane_valid   (lane_valid),
    .pass_idx     (pass_idx),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          start;
    logic          avail;
    logic          rd;
    logic [AW-1:0] addr;
    logic          fv;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass;
  } vec_t;

  vec_t vecs[$];
  logic [AW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void add(input logic st, input logic av, input logic rd,
                              input logic [AW-1:0] addr, input logic fv,
                              input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.avail = av; v.rd = rd; v.addr = addr;
    v.fv = fv; v.busy = bz; v.done = dn; v.pass = '0;
    vecs.push_back(v);
  endfunction

  // Cycle t: present the command for one cycle.
  task automatic issue_start(input logic [AW-1:0] base, input logic [LW-1:0] num,
                             input logic [PW-1:0] passes);
    @(posedge clk); #1;
    cfg_base_addr = base;
    cfg_vec_num   = num;
    cfg_pass_num  = passes;
    start         = 1'b1;
    buf_avail     = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      buf_avail = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"}, 32'(buf_rd_en), 32'd0);
    check({tag, " addr"}, 32'(buf_rd_addr), 32'd0);
    check({tag, " feed_valid"}, 32'(feed_valid), 32'd0);
    check({tag, " feed_zero"}, 32'(feed_zero), 32'd0);
    check({tag, " lane_valid"}, 32'(lane_valid), 32'd0);
    check({tag, " pass_idx"}, 32'(pass_idx), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " state"}, 32'(dbg_state), 32'd0);
  endtask

  // Apply vecs row by row (row i is cycle t+1+i) and compare at negedge.
  task automatic run_vecs(input string tag);
    logic [CH-1:0] fv_hist;
    logic          exp_fz;
    fv_hist = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      start = vecs[i].start;
      if (vecs[i].start) begin
        cfg_base_addr = 10'h2AA;
        cfg_vec_num   = 10'd1;
        cfg_pass_num  = 8'd5;
      end
      buf_avail = vecs[i].avail;
      fv_hist = {fv_hist[CH-2:0], vecs[i].fv};
      exp_fz = vecs[i].busy & ~vecs[i].fv;
      @(negedge clk);
      check($sformatf("%s c%0d rd_en", tag, i + 1), 32'(buf_rd_en), 32'(vecs[i].rd));
      if (vecs[i].rd)
        check($sformatf("%s c%0d addr", tag, i + 1), 32'(buf_rd_addr), 32'(vecs[i].addr));
      check($sformatf("%s c%0d feed_valid", tag, i + 1), 32'(feed_valid), 32'(vecs[i].fv));
      check($sformatf("%s c%0d feed_zero", tag, i + 1), 32'(feed_zero), 32'(exp_fz));
      check($sformatf("%s c%0d lane_valid", tag, i + 1), 32'(lane_valid), 32'(fv_hist));
      check($sformatf("%s c%0d busy", tag, i + 1), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("%s c%0d done", tag, i + 1), 32'(done), 32'(vecs[i].done));
      check($sformatf("%s c%0d pass_idx", tag, i + 1), 32'(pass_idx), 32'(vecs[i].pass));
    end
    idle_cycles(2);
  endtask

  // Single pass, 4 vectors, no bubbles; an optional junk start at cycles s1/s2.
  function automatic void fill_basic(input logic [AW-1:0] base, input int s1, input int s2);
    vecs.delete();
    for (int c = 1; c <= 14; c++)
      add((c == s1) || (c == s2), 1'b1, c <= 4, AW'(base + AW'(c - 1)),
          (c >= 2) && (c <= 5), c <= 13, c == 14);
  endfunction

  initial begin
    int done_cnt;
    logic exp_rd;
    logic [AW-1:0] a;

    // Reset block
    rstn = 1'b0; start = 1'b0; buf_avail = 1'b1;
    cfg_base_addr = '0; cfg_vec_num = '0; cfg_pass_num = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    idle_cycles(2);

    // Basic single pass
    fill_basic(10'h010, 0, 0);
    issue_start(10'h010, 10'd4, 8'd1);
    run_vecs("basic");

    // Bubble at t+2
    vecs.delete();
    add(1'b0, 1'b1, 1'b1, 10'h100, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'h101, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'h102, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0);
    for (int c = 6; c <= 13; c++)
      add(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    issue_start(10'h100, 10'd3, 8'd1);
    run_vecs("bubble");

    // Start while busy: junk command at t+2 and t+3 must be ignored
    fill_basic(10'h020, 2, 3);
    issue_start(10'h020, 10'd4, 8'd1);
    run_vecs("busy_start");

    // Multi-pass with address wrap
    exp_q.delete();
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(10'h3FF);
      exp_q.push_back(10'h000);
    end
    done_cnt = 0;
    issue_start(10'h3FF, 10'd2, 8'd3);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      buf_avail = 1'b1;
      @(negedge clk);
      exp_rd = (c == 1) || (c == 2) || (c == 12) || (c == 13) || (c == 23) || (c == 24);
      check($sformatf("multi c%0d rd_en", c), 32'(buf_rd_en), 32'(exp_rd));
      if (buf_rd_en) begin
        if (exp_q.size() == 0) begin
          check($sformatf("multi c%0d extra read", c), 32'd1, 32'd0);
        end else begin
          a = exp_q.pop_front();
          check($sformatf("multi c%0d addr", c), 32'(buf_rd_addr), 32'(a));
        end
      end
      if (c <= 33)
        check($sformatf("multi c%0d pass_idx", c), 32'(pass_idx),
              (c < 12) ? 32'd0 : (c < 23) ? 32'd1 : 32'd2);
      check($sformatf("multi c%0d done", c), 32'(done), 32'(c == 34));
      if (done) done_cnt++;
    end
    check("multi addr queue left", 32'(exp_q.size()), 32'd0);
    check("multi done count", 32'(done_cnt), 32'd1);

    // Zero length
    issue_start(10'h000, 10'd0, 8'd1);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("zero c1 done", 32'(done), 32'd1);
    check("zero c1 busy", 32'(busy), 32'd0);
    check("zero c1 rd_en", 32'(buf_rd_en), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero c2 done", 32'(done), 32'd0);
    check("zero c2 rd_en", 32'(buf_rd_en), 32'd0);
    idle_cycles(2);

    // Reset at vector 2 of pass 1, then a clean run
    issue_start(10'h040, 10'd4, 8'd2);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      buf_avail = 1'b1;
      if (c == 16) rstn = 1'b0;
      @(negedge clk);
    end
    check("rst pre pass_idx", 32'(pass_idx), 32'd1);
    check("rst pre rd_en", 32'(buf_rd_en), 32'd1);
    check("rst pre addr", 32'(buf_rd_addr), 32'h042);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("rst post");
    issue_start(10'h050, 10'd2, 8'd1);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      buf_avail = 1'b1;
      @(negedge clk);
      check($sformatf("rerun c%0d rd_en", c), 32'(buf_rd_en), 32'((c == 1) || (c == 2)));
      if (c <= 2)
        check($sformatf("rerun c%0d addr", c), 32'(buf_rd_addr), 32'(10'h050 + c - 1));
      if (c <= 11)
        check($sformatf("rerun c%0d pass_idx", c), 32'(pass_idx), 32'd0);
      check($sformatf("rerun c%0d done", c), 32'(done), 32'(c == 12));
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the input skew path of the conv unit. It reads input vectors from the input feature buffer and tells the skew stage when each byte lane holds real data. It drains the skew pipeline after each pass, and repeats the vector stream for a configured number of passes. It sits between the input buffer and the skew register array, which has no enable. This block therefore never stalls that array: bubbles are injected as zero vectors and tracked with per-lane valid bits.

## Interface
- REG_IN_CHANNEL_NUM, 9: byte lanes per vector; skew depth is REG_IN_CHANNEL_NUM-1.
- ADDR_WIDTH, 10: input buffer address width.
- LEN_WIDTH, 10: width of vector count.
- PASS_WIDTH, 8: width of pass count.
- BUF_RD_LATENCY, 1: buffer read latency in cycles (≥1).
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- cfg_base_addr  in  ADDR_WIDTH  first vector address.
- cfg_vec_num  in  LEN_WIDTH  vectors per pass.
- cfg_pass_num  in  PASS_WIDTH  passes; 0 treated as 1.
- buf_avail  in  1  buffer can serve the next read this cycle.
- buf_rd_en  out  1  read strobe.
- buf_rd_addr  out  ADDR_WIDTH  read address.
- feed_valid  out  1  vector at skew input is real; aligned to buffer data.
- feed_zero  out  1  equals ~feed_valid while busy; forces zero into skew input.
- lane_valid  out  REG_IN_CHANNEL_NUM  bit k = feed_valid delayed k cycles.
- pass_idx  out  PASS_WIDTH  current pass number, 0-based.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE:**
  - If start=1, capture all cfg_* inputs, clear the vector and pass counters, and go to FEED.
  - If start=1 with cfg_vec_num=0, go directly to DONE with no reads.
- **FEED:**
  - buf_rd_en = buf_avail.
  - buf_rd_addr = base + vec_idx.
  - vec_idx increments only on buf_rd_en.
  - A cycle with buf_avail=0 is a bubble: no read, and feed_valid=0 BUF_RD_LATENCY cycles later.
  - A read with vec_idx = cfg_vec_num-1 goes to DRAIN and loads drain_cnt = BUF_RD_LATENCY + REG_IN_CHANNEL_NUM - 1.
- **DRAIN:**
  - No reads.
  - drain_cnt decrements every cycle. At 1:
    - If pass_idx = last pass, go to DONE.
    - Otherwise increment pass_idx, clear vec_idx, and go to FEED. Passes re-read the same addresses.
- **DONE:** done=1 and busy=0 for one cycle, then IDLE.
- feed_valid is the buf_rd_en shift register of depth BUF_RD_LATENCY. lane_valid is the feed_valid shift chain.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- start while busy is ignored. cfg inputs outside IDLE are ignored.
- rstn=0 (any state, including mid-pass) takes effect at the next edge:
  - state returns to IDLE;
  - all counters and shift chains are cleared;
  - all outputs go to 0.
- Reset value of every output is 0, including feed_zero.

## Timing
- start accepted at edge t, which puts the block in FEED at cycle t+1. The first buf_rd_en can be t+1.
- feed_valid lags buf_rd_en by BUF_RD_LATENCY. lane_valid[k] lags feed_valid by k.
- Drain length is BUF_RD_LATENCY + REG_IN_CHANNEL_NUM - 1 = 9 cycles by default.
- On done, the last lane_valid[REG_IN_CHANNEL_NUM-1] pulse occurred in the previous cycle, so all lane_valid bits are 0 at done.
- Each pass costs (vectors + bubbles) + 9 cycles; passes run back-to-back with no gap beyond the drain.
- buf_avail is used combinationally for buf_rd_en. All other outputs are registered.

## Structure
- Shared package conv_feed_pkg holds:
  - the state encoding (IDLE/FEED/DRAIN/DONE);
  - the DRAIN_CYCLES function of BUF_RD_LATENCY and REG_IN_CHANNEL_NUM.
- One sub-module: lane_valid_skew. It is a REG_IN_CHANNEL_NUM-deep, 1-bit shift chain with synchronous active-low clear, producing lane_valid.
- Everything else (FSM, counters, address adder) lives in systolic_feed_ctrl. Expected size is about 150–250 lines.

## Test plan
- **Basic single pass:**
  - Stimulus: base=0x010, vec=4, pass=1, buf_avail=1, start at t.
  - rd_en at t+1..t+4 with addr 0x010..0x013.
  - feed_valid at t+2..t+5.
  - lane_valid[8] at t+10..t+13.
  - done at t+14, with busy low in the same cycle.
- **Bubble:**
  - Stimulus: vec=3, buf_avail low at t+2 only.
  - Reads at t+1, t+3, t+4.
  - feed_valid pattern 1,0,1,1 from t+2.
  - done at t+14.
- **Multi-pass:**
  - Stimulus: vec=2, pass=3, base=0x3FF.
  - Addresses per pass: 0x3FF, 0x000 (wrap).
  - pass_idx steps 0→1→2, each after a 9-cycle drain.
  - Exactly one done pulse, at t+34.
- **Zero length:** vec=0 → no rd_en, done at t+1.
- **Start while busy:** a second start mid-FEED leaves the address sequence and done timing unchanged.
- **Reset mid-op:**
  - Stimulus: rstn=0 for one edge at vector 2 of pass 1.
  - Next cycle all outputs are 0 and lane_valid is clear.
  - A new start after that runs normally from pass 0.
